score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 192 +++++++++++++++++++
 tb/tb_score_keeper.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Game score, lives and state tracker for the brick-breaker game.
// Events from the playfield are scored in BCD and drive the IDLE/PLAY/SERVE/OVER flow.
module score_keeper #(
    parameter int INIT_LIVES = 3,
    parameter int NUM_BRICKS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       brick_hit,
    input  logic       brick_cleared,
    input  logic       ball_lost,
    output logic [7:0] score_bcd,
    output logic [1:0] lives,
    output logic [1:0] state,
    output logic       ball_enable,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        SERVE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam logic [1:0] LIVES_LOAD  = 2'(INIT_LIVES);
    localparam logic [6:0] BRICKS_LOAD = 7'(NUM_BRICKS);

    game_state_t state_q;
    game_state_t state_d;

    logic       start_prev;
    logic       start_rise;
    logic [7:0] score_q;
    logic [7:0] score_d;
    logic [1:0] lives_q;
    logic [1:0] lives_d;
    logic [6:0] bricks_q;
    logic [6:0] bricks_d;
    logic       ball_enable_q;
    logic       ball_enable_d;
    logic       game_over_q;
    logic       game_over_d;
    logic       win_q;
    logic       win_d;

    logic [1:0] points;
    logic       win_event;
    logic       lose_event;
    logic       serve_event;

    // Adds 0..3 points to a two-digit BCD score, pinning the result at 99.
    function automatic logic [7:0] bcd_add_sat(input logic [7:0] value, input logic [1:0] add);
        logic [4:0] ones;
        logic [4:0] tens;
        logic [7:0] result;
        ones = {1'b0, value[3:0]} + {3'b000, add};
        tens = {1'b0, value[7:4]};
        if (ones > 5'd9) begin
            ones = ones - 5'd10;
            tens = tens + 5'd1;
        end
        if (tens > 5'd9) begin
            result = 8'h99;
        end else begin
            result = {tens[3:0], ones[3:0]};
        end
        return result;
    endfunction

    assign start_rise = start && !start_prev;

    // brick_cleared weighs 2 and brick_hit weighs 1, so the pair encodes the points directly.
    assign points = {brick_cleared, brick_hit};

    // Clearing the last brick wins even when the ball is lost in the same cycle.
    assign win_event   = brick_cleared && (bricks_q == 7'd1);
    assign lose_event  = ball_lost && (lives_q == 2'd1) && !win_event;
    assign serve_event = ball_lost && (lives_q > 2'd1) && !win_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            start_prev <= 1'b1;
        end else begin
            state_q    <= state_d;
            start_prev <= start;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (win_event || lose_event) begin
                    state_d = OVER;
                end else if (serve_event) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (start_rise) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (start_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        score_d  = score_q;
        lives_d  = lives_q;
        bricks_d = bricks_q;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    score_d  = 8'h00;
                    lives_d  = LIVES_LOAD;
                    bricks_d = BRICKS_LOAD;
                end
            end
            PLAY: begin
                score_d = bcd_add_sat(score_q, points);
                if (brick_cleared && (bricks_q != 7'd0)) begin
                    bricks_d = bricks_q - 7'd1;
                end
                if (lose_event) begin
                    lives_d = 2'd0;
                end else if (serve_event) begin
                    lives_d = lives_q - 2'd1;
                end
            end
            default: begin
                score_d  = score_q;
                lives_d  = lives_q;
                bricks_d = bricks_q;
            end
        endcase
    end

    // Status flags are computed from the upcoming state so they register alongside it.
    always_comb begin
        ball_enable_d = (state_d == PLAY);
        game_over_d   = (state_d == OVER);
        win_d         = 1'b0;
        if (state_d == OVER) begin
            if (state_q == PLAY) begin
                win_d = win_event;
            end else begin
                win_d = win_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q       <= 8'h00;
            lives_q       <= LIVES_LOAD;
            bricks_q      <= BRICKS_LOAD;
            ball_enable_q <= 1'b0;
            game_over_q   <= 1'b0;
            win_q         <= 1'b0;
        end else begin
            score_q       <= score_d;
            lives_q       <= lives_d;
            bricks_q      <= bricks_d;
            ball_enable_q <= ball_enable_d;
            game_over_q   <= game_over_d;
            win_q         <= win_d;
        end
    end

    assign score_bcd   = score_q;
    assign lives       = lives_q;
    assign state       = state_q;
    assign ball_enable = ball_enable_q;
    assign game_over   = game_over_q;
    assign win         = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a default-parameter instance for the main flow
// and a one-life, two-brick instance for the simultaneous win/loss case.
module tb_score_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       brick_hit;
    logic       brick_cleared;
    logic       ball_lost;
    logic [7:0] score_bcd;
    logic [1:0] lives;
    logic [1:0] state;
    logic       ball_enable;
    logic       game_over;
    logic       win;

    logic       b_rst;
    logic       b_start;
    logic       b_brick_hit;
    logic       b_brick_cleared;
    logic       b_ball_lost;
    logic [7:0] b_score_bcd;
    logic [1:0] b_lives;
    logic [1:0] b_state;
    logic       b_ball_enable;
    logic       b_game_over;
    logic       b_win;

    int assert_count = 0;
    int fail_count   = 0;

    score_keeper #(.INIT_LIVES(3), .NUM_BRICKS(64)) dut (
        .clk(clk), .rst(rst), .start(start),
        .brick_hit(brick_hit), .brick_cleared(brick_cleared), .ball_lost(ball_lost),
        .score_bcd(score_bcd), .lives(lives), .state(state),
        .ball_enable(ball_enable), .game_over(game_over), .win(win)
    );

    score_keeper #(.INIT_LIVES(1), .NUM_BRICKS(2)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start),
        .brick_hit(b_brick_hit), .brick_cleared(b_brick_cleared), .ball_lost(b_ball_lost),
        .score_bcd(b_score_bcd), .lives(b_lives), .state(b_state),
        .ball_enable(b_ball_enable), .game_over(b_game_over), .win(b_win)
    );

    function automatic logic [7:0] toBcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance whole cycles; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; brick_hit = 1'b0; brick_cleared = 1'b0; ball_lost = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_brick_hit = 1'b0; b_brick_cleared = 1'b0; b_ball_lost = 1'b0;
        applyStimulus(2);
        checkOutput("rst_state", {6'd0, state}, 8'd0);
        checkOutput("rst_score", score_bcd, 8'h00);
        checkOutput("rst_lives", {6'd0, lives}, 8'd3);
        checkOutput("rst_ball_enable", {7'd0, ball_enable}, 8'd0);
        checkOutput("rst_game_over", {7'd0, game_over}, 8'd0);
        checkOutput("rst_win", {7'd0, win}, 8'd0);
        checkOutput("rst_b_lives", {6'd0, b_lives}, 8'd1);

        // Start held through reset must not launch the game.
        rst = 1'b0; b_rst = 1'b0;
        applyStimulus(2);
        checkOutput("held_start_idle", {6'd0, state}, 8'd0);
        start = 1'b0;
        applyStimulus(1);
        checkOutput("start_low_idle", {6'd0, state}, 8'd0);
        start = 1'b1;
        applyStimulus(1);
        checkOutput("start_rise_play", {6'd0, state}, 8'd1);
        checkOutput("start_score", score_bcd, 8'h00);
        checkOutput("start_lives", {6'd0, lives}, 8'd3);
        checkOutput("start_ball_enable", {7'd0, ball_enable}, 8'd1);
        start = 1'b0;

        for (int i = 1; i <= 9; i++) begin
            brick_hit = 1'b1;
            applyStimulus(1);
            checkOutput("score_hit", score_bcd, toBcd(i));
        end
        brick_cleared = 1'b1;
        applyStimulus(1);
        checkOutput("score_bcd_carry", score_bcd, 8'h12);
        brick_cleared = 1'b0;
        applyStimulus(86);
        checkOutput("score_98", score_bcd, 8'h98);
        brick_hit = 1'b0;

        brick_cleared = 1'b1;
        applyStimulus(1);
        checkOutput("score_sat_clear", score_bcd, 8'h99);
        brick_cleared = 1'b0;
        brick_hit = 1'b1;
        applyStimulus(1);
        checkOutput("score_sat_hit", score_bcd, 8'h99);
        checkOutput("still_play", {6'd0, state}, 8'd1);
        brick_hit = 1'b0;

        ball_lost = 1'b1;
        applyStimulus(1);
        checkOutput("lost1_lives", {6'd0, lives}, 8'd2);
        checkOutput("lost1_state", {6'd0, state}, 8'd2);
        checkOutput("lost1_ball_enable", {7'd0, ball_enable}, 8'd0);
        checkOutput("lost1_score", score_bcd, 8'h99);
        applyStimulus(1);
        checkOutput("serve_lost_lives", {6'd0, lives}, 8'd2);
        checkOutput("serve_lost_state", {6'd0, state}, 8'd2);
        ball_lost = 1'b0;
        start = 1'b1;
        applyStimulus(1);
        checkOutput("serve_to_play", {6'd0, state}, 8'd1);
        checkOutput("serve_lives_kept", {6'd0, lives}, 8'd2);
        start = 1'b0;

        ball_lost = 1'b1;
        applyStimulus(1);
        ball_lost = 1'b0;
        checkOutput("lost2_lives", {6'd0, lives}, 8'd1);
        checkOutput("lost2_state", {6'd0, state}, 8'd2);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("serve2_to_play", {6'd0, state}, 8'd1);
        ball_lost = 1'b1;
        applyStimulus(1);
        ball_lost = 1'b0;
        checkOutput("lost3_lives", {6'd0, lives}, 8'd0);
        checkOutput("lost3_state", {6'd0, state}, 8'd3);
        checkOutput("lost3_win", {7'd0, win}, 8'd0);
        checkOutput("lost3_game_over", {7'd0, game_over}, 8'd1);
        checkOutput("lost3_ball_enable", {7'd0, ball_enable}, 8'd0);

        brick_hit = 1'b1;
        applyStimulus(1);
        brick_hit = 1'b0;
        checkOutput("over_hit_ignored", score_bcd, 8'h99);

        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("over_to_idle", {6'd0, state}, 8'd0);
        checkOutput("idle_game_over", {7'd0, game_over}, 8'd0);
        checkOutput("idle_score_held", score_bcd, 8'h99);
        checkOutput("idle_lives_held", {6'd0, lives}, 8'd0);
        applyStimulus(1);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("reload_state", {6'd0, state}, 8'd1);
        checkOutput("reload_score", score_bcd, 8'h00);
        checkOutput("reload_lives", {6'd0, lives}, 8'd3);

        brick_hit = 1'b1; brick_cleared = 1'b1;
        applyStimulus(12);
        brick_cleared = 1'b0;
        applyStimulus(1);
        checkOutput("score_37", score_bcd, 8'h37);

        // Reset wins over a concurrent brick event mid-PLAY.
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0; brick_hit = 1'b0;
        checkOutput("midrst_state", {6'd0, state}, 8'd0);
        checkOutput("midrst_score", score_bcd, 8'h00);
        checkOutput("midrst_lives", {6'd0, lives}, 8'd3);
        checkOutput("midrst_ball_enable", {7'd0, ball_enable}, 8'd0);
        checkOutput("midrst_game_over", {7'd0, game_over}, 8'd0);
        checkOutput("midrst_win", {7'd0, win}, 8'd0);
        applyStimulus(1);
        checkOutput("postrst_idle", {6'd0, state}, 8'd0);

        b_start = 1'b1;
        applyStimulus(1);
        b_start = 1'b0;
        checkOutput("b_play", {6'd0, b_state}, 8'd1);
        checkOutput("b_lives", {6'd0, b_lives}, 8'd1);
        b_brick_cleared = 1'b1;
        applyStimulus(1);
        checkOutput("b_first_clear_score", b_score_bcd, 8'h02);
        checkOutput("b_first_clear_state", {6'd0, b_state}, 8'd1);
        b_ball_lost = 1'b1;
        applyStimulus(1);
        b_brick_cleared = 1'b0; b_ball_lost = 1'b0;
        checkOutput("b_tie_state", {6'd0, b_state}, 8'd3);
        checkOutput("b_tie_win", {7'd0, b_win}, 8'd1);
        checkOutput("b_tie_lives", {6'd0, b_lives}, 8'd1);
        checkOutput("b_tie_game_over", {7'd0, b_game_over}, 8'd1);
        checkOutput("b_tie_score", b_score_bcd, 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
